player_move_ctrl: RTL and testbench



---
 rtl/player_move_ctrl.sv | 129 ++++++++++++
 tb/tb_player_move_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/player_move_ctrl.sv
// Player token motion: walks a snake-ordered board one tile per N frame ticks.
// Optional hop arc on the y output is enabled with `define PLAYER_HOP_ARC_EN.
module player_move_ctrl #(
    parameter int ORIGIN_X         = 64,
    parameter int ORIGIN_Y         = 48,
    parameter int TILE_W           = 32,
    parameter int TILE_H           = 32,
    parameter int LOG2_COLS        = 3,
    parameter int ROWS             = 4,
    parameter int LOG2_STEP_FRAMES = 3,
    parameter int HOP_STEP_PX      = 2
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        frame_tick,
    input  logic                                        move_start,
    input  logic [2:0]                                  move_steps,
    output logic [9:0]                                  player_x,
    output logic [9:0]                                  player_y,
    output logic [$clog2((1<<LOG2_COLS)*ROWS)-1:0]      cur_tile,
    output logic                                        busy,
    output logic                                        move_done
);
    localparam int COLS      = 1 << LOG2_COLS;
    localparam int NUM_TILES = COLS * ROWS;
    localparam int TW        = $clog2(NUM_TILES);
    localparam int FW        = LOG2_STEP_FRAMES;
    localparam int N         = 1 << FW;
    localparam int DX        = TILE_W / N;
    localparam int DY        = TILE_H / N;

    typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

    state_t        state, state_n;
    logic [TW-1:0] tile_q, next_tile;
    logic [2:0]    remaining;
    logic [FW-1:0] frame_cnt;
    logic [9:0]    base_x, base_y, tgt_x, tgt_y;
    logic          wrap, last_frame;

    // Odd rows run right to left; COLS is a power of two so COLS-1-col == ~col.
    function automatic logic [9:0] tile_x(input logic [TW-1:0] t);
        logic [LOG2_COLS-1:0] col;
        col = t[LOG2_COLS-1:0];
        if (t[LOG2_COLS]) col = ~col;
        return 10'(ORIGIN_X) + 10'(col) * 10'(TILE_W);
    endfunction

    function automatic logic [9:0] tile_y(input logic [TW-1:0] t);
        return 10'(ORIGIN_Y) + 10'(t[TW-1:LOG2_COLS]) * 10'(TILE_H);
    endfunction

    assign wrap       = (tile_q == TW'(NUM_TILES-1));
    assign next_tile  = wrap ? '0 : tile_q + 1'b1;
    assign tgt_x      = tile_x(next_tile);
    assign tgt_y      = tile_y(next_tile);
    assign last_frame = (frame_cnt == FW'(N-1));

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (move_start) state_n = (move_steps == 3'd0) ? DONE : STEP;
            STEP: if (frame_tick && last_frame && remaining == 3'd1) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tile_q    <= '0;
            remaining <= '0;
            frame_cnt <= '0;
            base_x    <= 10'(ORIGIN_X);
            base_y    <= 10'(ORIGIN_Y);
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (move_start) begin
                    remaining <= move_steps;
                    frame_cnt <= '0;
                end
                STEP: if (frame_tick) begin
                    if (last_frame) begin
                        base_x    <= tgt_x;
                        base_y    <= tgt_y;
                        tile_q    <= next_tile;
                        remaining <= remaining - 3'd1;
                        frame_cnt <= '0;
                    end else begin
                        frame_cnt <= frame_cnt + FW'(1);
                        // Wrap step holds position and snaps on the last tick.
                        if (!wrap) begin
                            if (tgt_x > base_x)      base_x <= base_x + 10'(DX);
                            else if (tgt_x < base_x) base_x <= base_x - 10'(DX);
                            else if (tgt_y > base_y) base_y <= base_y + 10'(DY);
                            else if (tgt_y < base_y) base_y <= base_y - 10'(DY);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign player_x  = base_x;
    assign cur_tile  = tile_q;
    assign busy      = (state != IDLE);
    assign move_done = (state == DONE);

`ifdef PLAYER_HOP_ARC_EN
    logic [FW:0] hop_k, hop_m;
    logic [9:0]  hop_off;

    // hop_k is frame_cnt after the latest tick (1..N), 0 before the first one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         hop_k <= '0;
        else if (state == IDLE)             hop_k <= '0;
        else if (state == STEP && frame_tick) hop_k <= {1'b0, frame_cnt} + (FW+1)'(1);
    end

    assign hop_m    = (hop_k > (FW+1)'(N/2)) ? (FW+1)'(N) - hop_k : hop_k;
    assign hop_off  = 10'(HOP_STEP_PX) * 10'(hop_m);
    assign player_y = (state == STEP) ? base_y - hop_off : base_y;
`else
    assign player_y = base_y;
`endif
endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl with a queue scoreboard of expected outputs.
module tb_player_move_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       move_start = 1'b0;
    logic [2:0] move_steps = 3'd0;
    logic [9:0] player_x, player_y;
    logic [4:0] cur_tile;
    logic       busy, move_done;

    player_move_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .move_start(move_start),
        .move_steps(move_steps), .player_x(player_x), .player_y(player_y),
        .cur_tile(cur_tile), .busy(busy), .move_done(move_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [26:0] v;
    } exp_t;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   m_tile   = 0;
    int   m_x      = 64;
    int   m_y      = 48;

    function automatic int tx(int t);
        int col = t % 8;
        int ce  = ((t / 8) % 2 == 1) ? 7 - col : col;
        return 64 + ce * 32;
    endfunction

    function automatic int ty(int t);
        return 48 + (t / 8) * 32;
    endfunction

    function automatic int interp(int s, int e, int i, bit wr);
        if (i == 8) return e;
        if (wr) return s;
        return s + (e - s) * i / 8;
    endfunction

    function automatic int hop(int i);
`ifdef PLAYER_HOP_ARC_EN
        return 2 * ((i < 8 - i) ? i : 8 - i);
`else
        return 0 * i;
`endif
    endfunction

    task automatic push_exp(string tag, int x, int y, int tile, bit b, bit d);
        exp_t e;
        e.tag = tag;
        e.v   = {10'(x), 10'(y), 5'(tile), b, d};
        q.push_back(e);
    endtask

    task automatic check_out();
        exp_t        e;
        logic [26:0] obs;
        e   = q.pop_front();
        obs = {player_x, player_y, cur_tile, busy, move_done};
        n_assert++;
        assert (obs === e.v) else begin
            n_fail++;
            $error("FAIL %s: observed x=%0d y=%0d tile=%0d busy=%b done=%b, expected x=%0d y=%0d tile=%0d busy=%b done=%b",
                   e.tag, player_x, player_y, cur_tile, busy, move_done,
                   e.v[26:17], e.v[16:7], e.v[6:2], e.v[1], e.v[0]);
        end
    endtask

    // Drive one clock cycle of inputs, then compare against the queued expectation.
    task automatic step(bit ft, bit ms, logic [2:0] st, string tag,
                        int x, int y, int tile, bit b, bit d);
        push_exp(tag, x, y, tile, b, d);
        frame_tick = ft; move_start = ms; move_steps = st;
        @(posedge clk); #1;
        frame_tick = 1'b0; move_start = 1'b0; move_steps = 3'd0;
        check_out();
    endtask

    task automatic do_move(int steps, bit coincide, bit inject, int rst_at);
        step(coincide, 1'b1, 3'(steps), "accept", m_x, m_y, m_tile, 1'b1, steps == 0);
        if (steps == 0) begin
            step(1'b0, 1'b0, 3'd0, "zero_idle", m_x, m_y, m_tile, 1'b0, 1'b0);
            return;
        end
        for (int s = 0; s < steps; s++) begin
            int nt = (m_tile == 31) ? 0 : m_tile + 1;
            int ex = tx(nt);
            int ey = ty(nt);
            bit wr = (m_tile == 31);
            for (int i = 1; i <= 8; i++) begin
                bit last = (i == 8) && (s == steps - 1);
                step(1'b0, inject && s == 0 && i == 4, 3'd3, inject && s == 0 && i == 4 ? "ignored_start" : "gap",
                     interp(m_x, ex, i - 1, wr), interp(m_y, ey, i - 1, wr) - hop(i - 1),
                     m_tile, 1'b1, 1'b0);
                if (s == 0 && i == rst_at) begin
                    #2 rst_n = 1'b0;
                    #1;
                    push_exp("async_reset", 64, 48, 0, 1'b0, 1'b0);
                    check_out();
                    @(negedge clk) rst_n = 1'b1;
                    m_tile = 0; m_x = 64; m_y = 48;
                    step(1'b1, 1'b0, 3'd0, "post_reset", 64, 48, 0, 1'b0, 1'b0);
                    return;
                end
                step(1'b1, 1'b0, 3'd0, last ? "tick_done" : "tick",
                     interp(m_x, ex, i, wr), interp(m_y, ey, i, wr) - hop(i),
                     (i == 8) ? nt : m_tile, 1'b1, last);
            end
            m_tile = nt; m_x = ex; m_y = ey;
        end
        step(1'b0, 1'b0, 3'd0, "back_idle", m_x, m_y, m_tile, 1'b0, 1'b0);
    endtask

    initial begin
        #12;
        push_exp("reset", 64, 48, 0, 1'b0, 1'b0);
        check_out();
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_move(1, 1'b1, 1'b0, 0);   // tile 0 -> 1, start coincides with a tick
        do_move(5, 1'b0, 1'b0, 0);   // -> 6
        do_move(2, 1'b0, 1'b1, 0);   // -> 8 across the row turn, with an ignored start
        do_move(0, 1'b0, 1'b0, 0);   // zero-step move
        do_move(7, 1'b0, 1'b0, 0);   // -> 15
        do_move(7, 1'b0, 1'b0, 0);   // -> 22
        do_move(7, 1'b0, 1'b0, 0);   // -> 29
        do_move(2, 1'b0, 1'b0, 0);   // -> 31 at (64,144)
        do_move(1, 1'b0, 1'b0, 0);   // wrap 31 -> 0
        do_move(3, 1'b0, 1'b0, 4);   // reset mid-step
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
